// File: rtl/uart_bus_master.sv
// UART-driven debug/boot bus master: parses W/R command frames from the receiver,
// performs one word access on the device bus and returns ACK or read data via the transmitter.
module uart_bus_master #(
    parameter int unsigned TIMEOUT_CYCLES = 2500000,
    parameter int unsigned TO_WIDTH       = 22
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxdReady_i,
    input  logic [7:0]  rxdData_i,
    input  logic        txdBusy_i,
    output logic        txdStart_o,
    output logic [7:0]  txdData_o,
    output logic        busReq_o,
    input  logic        busGnt_i,
    output logic        devEnable_o,
    output logic        devWrite_o,
    input  logic        devBusy_i,
    output logic [31:0] devPhysicalAddr_o,
    output logic [31:0] devDataSave_o,
    input  logic [31:0] devDataLoad_i,
    output logic [3:0]  devByteSelect_o
);
    // state       | meaning
    // S_IDLE      | waiting for a command byte
    // S_GET_ADDR  | collecting 4 address bytes, LSB first
    // S_GET_DATA  | collecting 4 write-data bytes, LSB first
    // S_REQ       | requesting the bus, waiting for grant
    // S_ACCESS    | strobe asserted until target not busy
    // S_SEND      | waiting for idle transmitter, then start one byte
    // S_SEND_WAIT | waiting for the started byte to finish
    typedef enum logic [2:0] {
        S_IDLE, S_GET_ADDR, S_GET_DATA, S_REQ, S_ACCESS, S_SEND, S_SEND_WAIT
    } state_t;

    localparam logic [7:0] CMD_W   = 8'h57;
    localparam logic [7:0] CMD_R   = 8'h52;
    localparam logic [7:0] RSP_ACK = 8'h06;
    localparam logic [7:0] RSP_NAK = 8'h15;
    localparam logic [TO_WIDTH-1:0] TO_RELOAD = TO_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t              state_q;
    logic                is_write_q;
    logic [1:0]          byte_cnt_q;
    logic [TO_WIDTH-1:0] timer_q;
    logic [31:0]         addr_q;
    logic [31:0]         data_q;
    logic [31:0]         tx_shift_q;
    logic [2:0]          tx_left_q;
    logic                skip_q;
    logic                bus_req_q;
    logic                dev_en_q;
    logic                txd_start_q;
    logic [7:0]          txd_data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            is_write_q  <= 1'b0;
            byte_cnt_q  <= '0;
            timer_q     <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            tx_shift_q  <= '0;
            tx_left_q   <= '0;
            skip_q      <= 1'b0;
            bus_req_q   <= 1'b0;
            dev_en_q    <= 1'b0;
            txd_start_q <= 1'b0;
            txd_data_q  <= '0;
        end else begin
            txd_start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (rxdReady_i) begin
                        if (rxdData_i == CMD_W || rxdData_i == CMD_R) begin
                            is_write_q <= (rxdData_i == CMD_W);
                            byte_cnt_q <= '0;
                            timer_q    <= TO_RELOAD;
                            addr_q     <= '0;
                            data_q     <= '0;
                            state_q    <= S_GET_ADDR;
                        end else begin
                            tx_shift_q <= {24'h0, RSP_NAK};
                            tx_left_q  <= 3'd1;
                            state_q    <= S_SEND;
                        end
                    end
                end
                S_GET_ADDR, S_GET_DATA: begin
                    if (rxdReady_i) begin
                        timer_q    <= TO_RELOAD;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (state_q == S_GET_ADDR) begin
                            // word address: the two byte-offset bits never reach the register
                            addr_q[8*byte_cnt_q +: 8] <= (byte_cnt_q == 2'd0) ?
                                                         {rxdData_i[7:2], 2'b00} : rxdData_i;
                        end else begin
                            data_q[8*byte_cnt_q +: 8] <= rxdData_i;
                        end
                        if (byte_cnt_q == 2'd3) begin
                            if (state_q == S_GET_ADDR && is_write_q) begin
                                state_q <= S_GET_DATA;
                            end else begin
                                bus_req_q <= 1'b1;
                                state_q   <= S_REQ;
                            end
                        end
                    end else if (timer_q == '0) begin
                        addr_q  <= '0;
                        data_q  <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        timer_q <= timer_q - TO_WIDTH'(1);
                    end
                end
                S_REQ: begin
                    if (busGnt_i) begin
                        dev_en_q <= 1'b1;
                        state_q  <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    // grant is deliberately ignored here: an access is never cut short
                    if (!devBusy_i) begin
                        dev_en_q  <= 1'b0;
                        bus_req_q <= 1'b0;
                        if (is_write_q) begin
                            tx_shift_q <= {24'h0, RSP_ACK};
                            tx_left_q  <= 3'd1;
                        end else begin
                            tx_shift_q <= devDataLoad_i;
                            tx_left_q  <= 3'd4;
                        end
                        state_q <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (!txdBusy_i) begin
                        txd_start_q <= 1'b1;
                        txd_data_q  <= tx_shift_q[7:0];
                        skip_q      <= 1'b1;
                        state_q     <= S_SEND_WAIT;
                    end
                end
                S_SEND_WAIT: begin
                    // transmitter raises busy one cycle late; skip that cycle
                    if (skip_q) begin
                        skip_q <= 1'b0;
                    end else if (!txdBusy_i) begin
                        if (tx_left_q == 3'd1) begin
                            state_q <= S_IDLE;
                        end else begin
                            tx_shift_q <= {8'h0, tx_shift_q[31:8]};
                            tx_left_q  <= tx_left_q - 3'd1;
                            state_q    <= S_SEND;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign txdStart_o        = txd_start_q;
    assign txdData_o         = txd_data_q;
    assign busReq_o          = bus_req_q;
    assign devEnable_o       = dev_en_q;
    assign devWrite_o        = dev_en_q & is_write_q;
    assign devPhysicalAddr_o = dev_en_q ? addr_q : '0;
    assign devDataSave_o     = dev_en_q ? data_q : '0;
    assign devByteSelect_o   = {4{dev_en_q}};

endmodule

// File: tb/tb_uart_bus_master.sv
// Bench for uart_bus_master: frame-level model predicts bus accesses and UART replies,
// a per-cycle monitor compares them, and directed tests pin timing with literal values.
`timescale 1ns/1ps
module tb_uart_bus_master;
    localparam int TO  = 100;
    localparam int TXB = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        rxdReady_i;
    logic [7:0]  rxdData_i;
    logic        txdBusy_i;
    logic        txdStart_o;
    logic [7:0]  txdData_o;
    logic        busReq_o;
    logic        busGnt_i;
    logic        devEnable_o;
    logic        devWrite_o;
    logic        devBusy_i;
    logic [31:0] devPhysicalAddr_o;
    logic [31:0] devDataSave_o;
    logic [31:0] devDataLoad_i;
    logic [3:0]  devByteSelect_o;

    uart_bus_master #(.TIMEOUT_CYCLES(TO), .TO_WIDTH(22)) dut (
        .clk(clk), .rst(rst),
        .rxdReady_i(rxdReady_i), .rxdData_i(rxdData_i),
        .txdBusy_i(txdBusy_i), .txdStart_o(txdStart_o), .txdData_o(txdData_o),
        .busReq_o(busReq_o), .busGnt_i(busGnt_i),
        .devEnable_o(devEnable_o), .devWrite_o(devWrite_o), .devBusy_i(devBusy_i),
        .devPhysicalAddr_o(devPhysicalAddr_o), .devDataSave_o(devDataSave_o),
        .devDataLoad_i(devDataLoad_i), .devByteSelect_o(devByteSelect_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } bus_t;

    int           checks = 0;
    int           failures = 0;
    bus_t         exp_bus[$];
    byte unsigned exp_tx[$];
    byte unsigned tx_log[$];
    int           en_cycles = 0;
    int           req_cycles = 0;
    logic [31:0]  last_en_addr = '0;
    logic [7:0]   last_tx = '0;
    bit           busy_prev = 1'b0;
    bit           mon_on = 1'b0;
    int           busy_hold = 0;
    int           acc_k = 0;
    int           tx_busy_cnt = 0;
    logic [31:0]  rd_value = '0;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Frame-level reference: what one complete frame must produce on bus and UART.
    task automatic model_frame(input byte unsigned f[$]);
        bus_t e;
        if (f.size() == 0) return;
        if (f[0] == 8'h57 || f[0] == 8'h52) begin
            e.wr = (f[0] == 8'h57);
            if (f.size() < (e.wr ? 9 : 5)) return;
            e.addr = {f[4], f[3], f[2], f[1]} & 32'hFFFF_FFFC;
            e.data = '0;
            if (e.wr) e.data = {f[8], f[7], f[6], f[5]};
            exp_bus.push_back(e);
            if (e.wr) exp_tx.push_back(8'h06);
            else for (int i = 0; i < 4; i++) exp_tx.push_back(rd_value[8*i +: 8]);
        end else begin
            exp_tx.push_back(8'h15);
        end
    endtask

    task automatic send_byte(input byte unsigned b);
        rxdReady_i = 1'b1;
        rxdData_i  = b;
        step();
        rxdReady_i = 1'b0;
        rxdData_i  = '0;
    endtask

    task automatic send_frame(input byte unsigned f[$], input int gap);
        model_frame(f);
        for (int i = 0; i < f.size(); i++) begin
            send_byte(f[i]);
            if (i != f.size() - 1) repeat (gap) step();
        end
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while ((exp_bus.size() != 0 || exp_tx.size() != 0) && n < 3000) begin
            step();
            n++;
        end
        chk32({name, "_completed"}, n < 3000, 1);
        exp_bus.delete();
        exp_tx.delete();
        repeat (TXB + 6) step();
    endtask

    task automatic clear_logs();
        tx_log.delete();
        en_cycles  = 0;
        req_cycles = 0;
    endtask

    task automatic check_all_zero(input string tag);
        chk32({tag, "_txdStart"}, txdStart_o, 0);
        chk32({tag, "_txdData"}, txdData_o, 0);
        chk32({tag, "_busReq"}, busReq_o, 0);
        chk32({tag, "_devEnable"}, devEnable_o, 0);
        chk32({tag, "_devWrite"}, devWrite_o, 0);
        chk32({tag, "_addr"}, devPhysicalAddr_o, 0);
        chk32({tag, "_wdata"}, devDataSave_o, 0);
        chk32({tag, "_bytesel"}, devByteSelect_o, 0);
    endtask

    // Target and transmitter responders, driven just after each rising edge.
    initial begin
        devBusy_i = 1'b0;
        txdBusy_i = 1'b0;
        forever begin
            step();
            if (devEnable_o) begin
                acc_k++;
                devBusy_i = (acc_k <= busy_hold);
            end else begin
                acc_k     = 0;
                devBusy_i = 1'b0;
            end
            if (tx_busy_cnt > 0) begin
                txdBusy_i = 1'b1;
                tx_busy_cnt--;
            end else begin
                txdBusy_i = 1'b0;
            end
        end
    end

    // Per-cycle compare against the model queues.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_on && !rst) begin
                if (busReq_o) req_cycles++;
                if (devEnable_o) begin
                    en_cycles++;
                    last_en_addr = devPhysicalAddr_o;
                    chk32("req_during_enable", busReq_o, 1);
                    chk32("bytesel_active", devByteSelect_o, 4'hf);
                    chk32("access_expected", exp_bus.size() > 0, 1);
                    if (exp_bus.size() > 0) begin
                        chk32("dev_write", devWrite_o, exp_bus[0].wr);
                        chk32("dev_addr", devPhysicalAddr_o, exp_bus[0].addr);
                        if (exp_bus[0].wr) chk32("dev_wdata", devDataSave_o, exp_bus[0].data);
                        if (!devBusy_i) void'(exp_bus.pop_front());
                    end
                end else begin
                    chk32("bytesel_idle", devByteSelect_o, 0);
                    chk32("write_idle", devWrite_o, 0);
                end
                if (txdStart_o) begin
                    chk32("tx_start_while_busy", busy_prev, 0);
                    chk32("tx_expected", exp_tx.size() > 0, 1);
                    if (exp_tx.size() > 0) chk32("tx_byte", txdData_o, exp_tx.pop_front());
                    tx_log.push_back(txdData_o);
                    last_tx     = txdData_o;
                    tx_busy_cnt = TXB;
                end else if (txdBusy_i) begin
                    chk32("tx_data_stable", txdData_o, last_tx);
                end
                busy_prev = txdBusy_i;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        byte unsigned fr[$];
        int n;
        rst = 1'b1; rxdReady_i = 1'b0; rxdData_i = '0; busGnt_i = 1'b0; devDataLoad_i = '0;
        repeat (3) step();
        check_all_zero("reset");
        rst = 1'b0;
        mon_on = 1'b1;
        repeat (2) step();

        // write, grant tied high, minimum latency
        clear_logs();
        busGnt_i = 1'b1; busy_hold = 0;
        fr = {8'h57, 8'h10, 8'h00, 8'h00, 8'h80, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_frame(fr, 2);
        @(negedge clk);
        chk32("lat1_enable", devEnable_o, 0);
        chk32("lat1_req", busReq_o, 1);
        @(negedge clk);
        chk32("lat2_enable", devEnable_o, 1);
        chk32("wr_addr_lit", devPhysicalAddr_o, 32'h8000_0010);
        chk32("wr_data_lit", devDataSave_o, 32'hDEAD_BEEF);
        chk32("wr_write_lit", devWrite_o, 1);
        step();
        wait_done("write1");
        chk32("wr_en_cycles", en_cycles, 1);
        chk32("wr_tx_count", tx_log.size(), 1);
        if (tx_log.size() > 0) chk32("wr_ack_lit", tx_log[0], 8'h06);

        // read with a slow target
        clear_logs();
        busy_hold = 3; rd_value = 32'h1234_5678; devDataLoad_i = rd_value;
        fr = {8'h52, 8'h04, 8'h00, 8'h00, 8'h80};
        send_frame(fr, 3);
        wait_done("read1");
        chk32("rd_en_cycles", en_cycles, 4);
        chk32("rd_addr_lit", last_en_addr, 32'h8000_0004);
        chk32("rd_tx_count", tx_log.size(), 4);
        if (tx_log.size() == 4) begin
            chk32("rd_b0", tx_log[0], 8'h78);
            chk32("rd_b1", tx_log[1], 8'h56);
            chk32("rd_b2", tx_log[2], 8'h34);
            chk32("rd_b3", tx_log[3], 8'h12);
        end

        // unknown command, then a write with low address bits set
        clear_logs();
        fr = {8'h41};
        send_frame(fr, 0);
        wait_done("nak");
        chk32("nak_no_req", req_cycles, 0);
        chk32("nak_tx_count", tx_log.size(), 1);
        if (tx_log.size() > 0) chk32("nak_lit", tx_log[0], 8'h15);
        clear_logs();
        busy_hold = 1;
        fr = {8'h57, 8'h13, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
        send_frame(fr, 1);
        wait_done("after_nak");
        chk32("addr_lsb_drop_lit", last_en_addr, 32'h0000_0010);
        chk32("after_nak_en_cycles", en_cycles, 2);

        // partial frame times out silently; slow-but-in-time frame still works
        clear_logs();
        fr = {8'h52, 8'h00};
        send_frame(fr, 0);
        repeat (TO + 1) step();
        chk32("to_no_req", req_cycles, 0);
        chk32("to_no_tx", tx_log.size(), 0);
        busy_hold = 0; rd_value = 32'hA5C3_0F81; devDataLoad_i = rd_value;
        fr = {8'h52, 8'h08, 8'h00, 8'h00, 8'h00};
        send_frame(fr, TO - 2);
        wait_done("after_timeout");
        chk32("after_to_addr", last_en_addr, 32'h0000_0008);
        chk32("after_to_tx_count", tx_log.size(), 4);
        if (tx_log.size() == 4) begin
            chk32("after_to_b0", tx_log[0], 8'h81);
            chk32("after_to_b3", tx_log[3], 8'hA5);
        end

        // grant withheld for 10 cycles, then revoked mid-access
        clear_logs();
        busGnt_i = 1'b0; busy_hold = 3;
        fr = {8'h57, 8'h20, 8'h00, 8'h00, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
        send_frame(fr, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk32("nogrant_req", busReq_o, 1);
            chk32("nogrant_enable", devEnable_o, 0);
            step();
        end
        busGnt_i = 1'b1;
        @(negedge clk);
        chk32("grant_cycle_enable", devEnable_o, 0);
        step();
        @(negedge clk);
        chk32("grant_next_enable", devEnable_o, 1);
        step();
        busGnt_i = 1'b0;
        wait_done("grant_drop");
        chk32("grant_drop_en_cycles", en_cycles, 4);
        busGnt_i = 1'b1;

        // asynchronous reset in the middle of an access
        clear_logs();
        busy_hold = 50; rd_value = 32'hCAFE_F00D; devDataLoad_i = rd_value;
        fr = {8'h52, 8'h40, 8'h00, 8'h00, 8'h00};
        send_frame(fr, 1);
        n = 0;
        while (!devEnable_o && n < 20) begin
            step();
            n++;
        end
        chk32("rst_access_reached", n < 20, 1);
        repeat (2) step();
        #1;
        rst = 1'b1;
        mon_on = 1'b0;
        #1;
        check_all_zero("async_rst");
        exp_bus.delete();
        exp_tx.delete();
        repeat (2) step();
        rst = 1'b0;
        clear_logs();
        mon_on = 1'b1;
        repeat (30) step();
        chk32("post_rst_no_tx", tx_log.size(), 0);
        chk32("post_rst_no_req", req_cycles, 0);

        // bytes arriving while a reply is in flight are dropped
        clear_logs();
        fr = {8'h41};
        send_frame(fr, 0);
        send_byte(8'h52);
        send_byte(8'h41);
        wait_done("rx_during_send");
        chk32("rx_during_send_tx_count", tx_log.size(), 1);
        if (tx_log.size() > 0) chk32("rx_during_send_lit", tx_log[0], 8'h15);
        chk32("rx_during_send_no_req", req_cycles, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
